imu_poll_sequencer: RTL and testbench

//  Transaction sequencer that sits directly upstream of the general I2C master and drives its command port.

---
 rtl/imu_poll_sequencer_if.sv | 37 +++
 rtl/imu_poll_sequencer.sv | 275 +++++++++++++++++++++++++++
 tb/tb_imu_poll_sequencer.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imu_poll_sequencer_if.sv
// rtl/imu_poll_sequencer_if.sv - command/status bundle between the IMU poll sequencer and the I2C master
//
// master modport : sequencer side (drives the command, receives status/read data)
// slave modport  : I2C master side (receives the command, drives status/read data)
//   i2c_start       request a transaction
//   i2c_rw          0 = pointer write, 1 = read
//   i2c_slave_addr  7-bit device address
//   i2c_w_data      byte to write (register pointer)
//   i2c_data_len    number of bytes in the transaction
//   i2c_r_data      byte returned by a read
//   i2c_busy        transaction in progress
//   i2c_ack_error   NACK flag, valid when i2c_done rises
//   i2c_done        transaction complete (level, may stay high)

`timescale 1ns/1ps

interface imu_poll_sequencer_if;
    logic       i2c_start;
    logic       i2c_rw;
    logic [6:0] i2c_slave_addr;
    logic [7:0] i2c_w_data;
    logic [1:0] i2c_data_len;
    logic [7:0] i2c_r_data;
    logic       i2c_busy;
    logic       i2c_ack_error;
    logic       i2c_done;

    modport master (
        output i2c_start, i2c_rw, i2c_slave_addr, i2c_w_data, i2c_data_len,
        input  i2c_r_data, i2c_busy, i2c_ack_error, i2c_done
    );

    modport slave (
        input  i2c_start, i2c_rw, i2c_slave_addr, i2c_w_data, i2c_data_len,
        output i2c_r_data, i2c_busy, i2c_ack_error, i2c_done
    );
endinterface

// File: rtl/imu_poll_sequencer.sv
// rtl/imu_poll_sequencer.sv - periodic 3-axis IMU poller driving a general I2C master
//
// Every POLL_PERIOD cycles (while enabled) reads NUM_BYTES data registers starting at REG_BASE,
// each as a 1-byte pointer write followed by a 1-byte read, and publishes big-endian X/Y/Z samples.
// Optional feature macro: IMU_RETRY_EN (reissue a failing byte from its pointer write up to MAX_RETRY times).
//
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   enable          polling enable (acted on in IDLE / WAIT_TICK)
//   i2c             command/status bundle to the I2C master (master modport)
//   sample_x/y/z    last complete sample, two's complement
//   sample_valid    one-cycle strobe coincident with a sample update
//   seq_busy        high while a sample sequence is in flight
//   err_count       number of aborted samples, saturating

`timescale 1ns/1ps

module imu_poll_sequencer #(
    parameter logic [6:0] SLAVE_ADDR     = 7'h68,
    parameter logic [7:0] REG_BASE       = 8'h3B,
    parameter int         NUM_BYTES      = 6,
    parameter int         POLL_PERIOD    = 100000,
    parameter int         TIMEOUT_CYCLES = 200000,
    parameter int         MAX_RETRY      = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    imu_poll_sequencer_if.master       i2c,
    output logic [15:0]                sample_x,
    output logic [15:0]                sample_y,
    output logic [15:0]                sample_z,
    output logic                       sample_valid,
    output logic                       seq_busy,
    output logic [7:0]                 err_count
);

`ifdef IMU_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    localparam int PCNT_W = $clog2(POLL_PERIOD + 1);
    localparam int WD_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam int RTY_W  = $clog2(MAX_RETRY + 2);
    localparam int IDX_W  = $clog2(NUM_BYTES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_TICK,
        S_PTR_REQ,
        S_PTR_WAIT,
        S_RD_REQ,
        S_RD_WAIT,
        S_PUBLISH,
        S_FAIL
    } state_t;

    state_t                         state_q, state_d;
    logic [IDX_W-1:0]               idx_q, idx_d;
    logic [NUM_BYTES-1:0][7:0]      shadow_q, shadow_d;
    logic [15:0]                    sample_x_q, sample_x_d;
    logic [15:0]                    sample_y_q, sample_y_d;
    logic [15:0]                    sample_z_q, sample_z_d;
    logic                           sample_valid_q, sample_valid_d;
    logic [7:0]                     err_q, err_d;
    logic [PCNT_W-1:0]              cnt_q, cnt_d;
    logic [WD_W-1:0]                wd_q, wd_d;
    logic [RTY_W-1:0]               retry_q, retry_d;
    logic [1:0]                     busy_sync_q, busy_sync_d;
    logic [1:0]                     done_sync_q, done_sync_d;
    logic [1:0]                     ack_sync_q, ack_sync_d;
    logic                           done_prev_q, done_prev_d;

    logic busy_s, done_s, ack_s, done_rise;
    logic tick, in_txn, in_req, timeout;
    logic err_evt, wd_restart;

    // Master status crosses in through plain 2-flop synchronisers; done_prev
    // is one more stage so the edge is detected on settled values only.
    always_comb begin
        busy_sync_d = {busy_sync_q[0], i2c.i2c_busy};
        done_sync_d = {done_sync_q[0], i2c.i2c_done};
        ack_sync_d  = {ack_sync_q[0],  i2c.i2c_ack_error};
        done_prev_d = done_sync_q[1];
    end

    assign busy_s    = busy_sync_q[1];
    assign done_s    = done_sync_q[1];
    assign ack_s     = ack_sync_q[1];
    assign done_rise = done_s & ~done_prev_q;

    // Period counter: the roll cycle is the tick; parked at zero while disabled.
    assign tick = enable && (cnt_q == PCNT_W'(POLL_PERIOD - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (!enable) begin
            cnt_d = '0;
        end else if (tick) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign in_req  = (state_q == S_PTR_REQ) || (state_q == S_RD_REQ);
    assign in_txn  = in_req || (state_q == S_PTR_WAIT) || (state_q == S_RD_WAIT);
    assign timeout = in_txn && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        shadow_d       = shadow_q;
        sample_x_d     = sample_x_q;
        sample_y_d     = sample_y_q;
        sample_z_d     = sample_z_q;
        sample_valid_d = 1'b0;
        err_d          = err_q;
        retry_d        = retry_q;
        err_evt        = 1'b0;
        wd_restart     = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_WAIT_TICK;
                end
            end
            S_WAIT_TICK: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (tick) begin
                    idx_d   = '0;
                    retry_d = '0;
                    state_d = S_PTR_REQ;
                end
            end
            S_PTR_REQ: begin
                if (timeout) begin
                    err_evt = 1'b1;
                end else if (busy_s) begin
                    state_d = S_PTR_WAIT;
                end
            end
            S_PTR_WAIT: begin
                if (done_rise) begin
                    if (ack_s) begin
                        err_evt = 1'b1;
                    end else begin
                        state_d = S_RD_REQ;
                    end
                end else if (timeout) begin
                    err_evt = 1'b1;
                end
            end
            S_RD_REQ: begin
                if (timeout) begin
                    err_evt = 1'b1;
                end else if (busy_s) begin
                    state_d = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (done_rise) begin
                    if (ack_s) begin
                        err_evt = 1'b1;
                    end else begin
                        shadow_d[idx_q] = i2c.i2c_r_data;
                        if (idx_q == IDX_W'(NUM_BYTES - 1)) begin
                            state_d = S_PUBLISH;
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            retry_d = '0;
                            state_d = S_PTR_REQ;
                        end
                    end
                end else if (timeout) begin
                    err_evt = 1'b1;
                end
            end
            S_PUBLISH: begin
                sample_x_d     = {shadow_q[0], shadow_q[1]};
                sample_y_d     = {shadow_q[2], shadow_q[3]};
                sample_z_d     = {shadow_q[4], shadow_q[5]};
                sample_valid_d = 1'b1;
                idx_d          = '0;
                retry_d        = '0;
                state_d        = S_WAIT_TICK;
            end
            S_FAIL: begin
                if (err_q != 8'hFF) begin
                    err_d = err_q + 8'd1;
                end
                idx_d   = '0;
                retry_d = '0;
                state_d = S_WAIT_TICK;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A failed byte is retried from its pointer write; the retry path may
        // stay in PTR_REQ, so the watchdog is restarted explicitly.
        if (err_evt) begin
            if (RETRY_EN && (retry_q < RTY_W'(MAX_RETRY))) begin
                retry_d    = retry_q + 1'b1;
                wd_restart = 1'b1;
                state_d    = S_PTR_REQ;
            end else begin
                state_d = S_FAIL;
            end
        end

        if (in_txn && (state_d == state_q) && !wd_restart) begin
            wd_d = wd_q + 1'b1;
        end else begin
            wd_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= S_IDLE;
            idx_q          <= '0;
            shadow_q       <= '0;
            sample_x_q     <= '0;
            sample_y_q     <= '0;
            sample_z_q     <= '0;
            sample_valid_q <= 1'b0;
            err_q          <= '0;
            cnt_q          <= '0;
            wd_q           <= '0;
            retry_q        <= '0;
            busy_sync_q    <= '0;
            done_sync_q    <= '0;
            ack_sync_q     <= '0;
            done_prev_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            shadow_q       <= shadow_d;
            sample_x_q     <= sample_x_d;
            sample_y_q     <= sample_y_d;
            sample_z_q     <= sample_z_d;
            sample_valid_q <= sample_valid_d;
            err_q          <= err_d;
            cnt_q          <= cnt_d;
            wd_q           <= wd_d;
            retry_q        <= retry_d;
            busy_sync_q    <= busy_sync_d;
            done_sync_q    <= done_sync_d;
            ack_sync_q     <= ack_sync_d;
            done_prev_q    <= done_prev_d;
        end
    end

    // i2c_start is decoded from registered state so it falls in the very cycle
    // busy is seen, on a watchdog expiry, and asynchronously with reset.
    assign i2c.i2c_start      = in_req && !busy_s && !timeout;
    assign i2c.i2c_rw         = (state_q == S_RD_REQ) || (state_q == S_RD_WAIT);
    assign i2c.i2c_w_data     = REG_BASE + 8'(idx_q);
    assign i2c.i2c_slave_addr = SLAVE_ADDR;
    assign i2c.i2c_data_len   = 2'd1;

    assign sample_x     = sample_x_q;
    assign sample_y     = sample_y_q;
    assign sample_z     = sample_z_q;
    assign sample_valid = sample_valid_q;
    assign seq_busy     = (state_q != S_IDLE) && (state_q != S_WAIT_TICK);
    assign err_count    = err_q;

endmodule

// File: tb/tb_imu_poll_sequencer.sv
// tb/tb_imu_poll_sequencer.sv - self-checking bench for imu_poll_sequencer

`timescale 1ns/1ps

module tb_imu_poll_sequencer;

    localparam logic [7:0] REG_BASE = 8'h3B;
    localparam int POLL = 60;
    localparam int TO   = 40;
    localparam int MAXR = 3;
`ifdef IMU_RETRY_EN
    localparam bit RETRY = 1'b1;
`else
    localparam bit RETRY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [15:0] sx, sy, sz;
    logic        sv, sb;
    logic [7:0]  ec;

    imu_poll_sequencer_if bus();

    imu_poll_sequencer #(
        .SLAVE_ADDR(7'h68), .REG_BASE(REG_BASE), .NUM_BYTES(6),
        .POLL_PERIOD(POLL), .TIMEOUT_CYCLES(TO), .MAX_RETRY(MAXR)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .i2c(bus),
        .sample_x(sx), .sample_y(sy), .sample_z(sz),
        .sample_valid(sv), .seq_busy(sb), .err_count(ec)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic [7:0] data_b [6];
    int  plan [2][6];
    int  plan_gen = 0;
    bit  hang = 1'b0;
    int  log_q [$];
    int  pulse_cnt = 0;
    int  overlap_cnt = 0;
    int  m_phase = 0;

    int          exp_err = 0;
    logic [15:0] exp_x = '0, exp_y = '0, exp_z = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Behavioural I2C master + sensor: accepts a start, raises busy after a short
    // random delay, then drops busy and raises done (held until the next start).
    initial begin : master
        int  cnt;
        int  used [2][6];
        int  seen_gen;
        bit  cur_nack;
        bit  cur_rw;
        int  cur_idx;
        seen_gen = -1;
        cnt = 0;
        cur_nack = 1'b0;
        cur_rw = 1'b0;
        cur_idx = 0;
        bus.i2c_busy = 1'b0;
        bus.i2c_done = 1'b0;
        bus.i2c_ack_error = 1'b0;
        bus.i2c_r_data = 8'h00;
        forever begin
            @(posedge clk); #1;
            if (seen_gen != plan_gen) begin
                used = plan;
                seen_gen = plan_gen;
            end
            if (reset) begin
                bus.i2c_busy = 1'b0;
                bus.i2c_done = 1'b0;
                bus.i2c_ack_error = 1'b0;
                m_phase = 0;
            end else begin
                case (m_phase)
                    0: if (bus.i2c_start && !hang) begin
                        cur_rw  = bus.i2c_rw;
                        cur_idx = int'(bus.i2c_w_data) - int'(REG_BASE);
                        log_q.push_back((cur_rw ? 256 : 0) + int'(bus.i2c_w_data));
                        cur_nack = 1'b0;
                        if (cur_idx >= 0 && cur_idx < 6 && used[cur_rw][cur_idx] > 0) begin
                            used[cur_rw][cur_idx]--;
                            cur_nack = 1'b1;
                        end
                        bus.i2c_done = 1'b0;
                        cnt = $urandom_range(1, 3);
                        m_phase = 1;
                    end
                    1: begin
                        cnt--;
                        if (cnt == 0) begin
                            bus.i2c_busy = 1'b1;
                            cnt = $urandom_range(4, 8);
                            m_phase = 2;
                        end
                    end
                    default: begin
                        cnt--;
                        if (cnt == 0) begin
                            bus.i2c_busy = 1'b0;
                            bus.i2c_done = 1'b1;
                            bus.i2c_ack_error = cur_nack;
                            bus.i2c_r_data = (cur_rw && cur_idx >= 0 && cur_idx < 6) ?
                                             data_b[cur_idx] : 8'($urandom);
                            m_phase = 0;
                        end
                    end
                endcase
            end
        end
    end

    initial begin : monitor
        logic prev_start;
        prev_start = 1'b0;
        forever begin
            @(negedge clk);
            if (sv) pulse_cnt++;
            if (bus.i2c_start && !prev_start && bus.i2c_busy) overlap_cnt++;
            prev_start = bus.i2c_start;
        end
    end

    initial begin : global_guard
        #600000;
        $display("FAIL global_timeout: observed=running expected=finished");
        $fatal(1, "bench timed out");
    end

    task automatic clear_plan();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 6; i++) plan[r][i] = 0;
    endtask

    task automatic load_data(input bit fixed, output logic [7:0] d [6]);
        logic [7:0] f [6];
        f = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
        for (int i = 0; i < 6; i++) begin
            d[i] = fixed ? f[i] : 8'($urandom);
            data_b[i] = d[i];
        end
    endtask

    // One sample attempt: the expected request sequence and outcome are derived
    // from the NACK plan, then the DUT is enabled for exactly one tick.
    task automatic run_attempt(input string tag, input bit fixed, input bit hang_mode);
        int exp_req [$];
        int pn [2][6];
        logic [7:0] d [6];
        bit ok, failed, fin;
        int retries, base_log, base_pulse, waited, mism, nlog;

        load_data(fixed, d);
        pn = plan;
        plan_gen++;
        hang = hang_mode;
        ok = 1'b1;
        for (int idx = 0; idx < 6 && ok; idx++) begin
            retries = 0;
            fin = 1'b0;
            while (!fin && ok) begin
                failed = 1'b0;
                if (hang_mode) begin
                    failed = 1'b1;
                end else begin
                    exp_req.push_back((int'(REG_BASE) + idx) % 256);
                    if (pn[0][idx] > 0) begin
                        pn[0][idx]--;
                        failed = 1'b1;
                    end else begin
                        exp_req.push_back(256 + (int'(REG_BASE) + idx) % 256);
                        if (pn[1][idx] > 0) begin
                            pn[1][idx]--;
                            failed = 1'b1;
                        end
                    end
                end
                if (!failed) fin = 1'b1;
                else if (RETRY && retries < MAXR) retries++;
                else ok = 1'b0;
            end
        end

        base_log = log_q.size();
        base_pulse = pulse_cnt;
        @(posedge clk); #1;
        enable = 1'b1;
        waited = 0;
        while (!sb && waited < 3 * POLL) begin @(posedge clk); #1; waited++; end
        check({tag, "_began"}, sb, 1);
        enable = 1'b0;
        waited = 0;
        while (sb && waited < 5000) begin @(posedge clk); #1; waited++; end
        check({tag, "_ended"}, sb, 0);
        repeat (3) @(posedge clk);
        #1;

        if (ok) begin
            exp_x = {d[0], d[1]};
            exp_y = {d[2], d[3]};
            exp_z = {d[4], d[5]};
        end else if (exp_err < 255) begin
            exp_err++;
        end
        check({tag, "_pulses"}, pulse_cnt - base_pulse, ok ? 1 : 0);
        check({tag, "_err"}, ec, exp_err);
        check({tag, "_xyz"}, {sx, sy, sz}, {exp_x, exp_y, exp_z});
        nlog = log_q.size() - base_log;
        check({tag, "_nreq"}, nlog, exp_req.size());
        mism = 0;
        for (int i = 0; i < exp_req.size(); i++)
            if (i >= nlog || log_q[base_log + i] != exp_req[i]) mism++;
        check({tag, "_reqseq"}, mism, 0);
        check({tag, "_start_low"}, bus.i2c_start, 0);
        hang = 1'b0;
        clear_plan();
    endtask

    initial begin : main
        logic [7:0] d [6];
        int waited, base_log, base_pulse, nlog, mism, npulse;

        clear_plan();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {bus.i2c_start, bus.i2c_rw, bus.i2c_w_data, sv, sb, ec},
              {1'b0, 1'b0, REG_BASE, 1'b0, 1'b0, 8'h00});
        check("reset_samples", {sx, sy, sz}, 48'h0);
        check("static_outputs", {bus.i2c_slave_addr, bus.i2c_data_len}, {7'h68, 2'd1});
        reset = 1'b0;

        // Known pattern, pointers 3B..40
        run_attempt("basic", 1'b1, 1'b0);
        check("basic_x", sx, 16'h1234);
        check("basic_z", sz, 16'h9ABC);

        // NACK on pointer write of byte 3, then a clean sample
        plan[0][3] = 1;
        run_attempt("nack_ptr3", 1'b0, 1'b0);
        run_attempt("after_nack", 1'b0, 1'b0);

        // Two NACKs on the byte-2 read
        plan[1][2] = 2;
        run_attempt("nack_rd2", 1'b0, 1'b0);

        // Master never responds
        run_attempt("hang", 1'b0, 1'b1);

        // Reset while the byte-4 read is in flight
        load_data(1'b0, d);
        plan_gen++;
        base_log = log_q.size();
        @(posedge clk); #1;
        enable = 1'b1;
        waited = 0;
        while (waited < 5000 && !(log_q.size() > base_log && log_q[log_q.size() - 1] == 256 + 8'h3F)) begin
            @(posedge clk); #1; waited++;
        end
        check("rst_reached_rd4", (waited < 5000), 1);
        enable = 1'b0;
        waited = 0;
        while (m_phase != 2 && waited < 50) begin @(posedge clk); #1; waited++; end
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy_before", sb, 1);
        reset = 1'b1;
        #1;
        check("rst_mid_outputs", {bus.i2c_start, bus.i2c_rw, bus.i2c_w_data, sv, sb, ec},
              {1'b0, 1'b0, REG_BASE, 1'b0, 1'b0, 8'h00});
        check("rst_mid_samples", {sx, sy, sz}, 48'h0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_err = 0;
        exp_x = '0; exp_y = '0; exp_z = '0;
        run_attempt("after_rst", 1'b0, 1'b0);

        // Continuous polling with a period shorter than one sample
        load_data(1'b0, d);
        plan_gen++;
        base_log = log_q.size();
        base_pulse = pulse_cnt;
        @(posedge clk); #1;
        enable = 1'b1;
        waited = 0;
        while (pulse_cnt - base_pulse < 2 && waited < 8000) begin @(posedge clk); #1; waited++; end
        enable = 1'b0;
        waited = 0;
        while (sb && waited < 5000) begin @(posedge clk); #1; waited++; end
        repeat (3) @(posedge clk);
        #1;
        npulse = pulse_cnt - base_pulse;
        nlog = log_q.size() - base_log;
        check("cont_two_samples", (npulse >= 2), 1);
        check("cont_nreq", nlog, 12 * npulse);
        mism = 0;
        for (int i = 0; i < nlog; i++)
            if (log_q[base_log + i] != ((i % 2) ? 256 : 0) + int'(REG_BASE) + (i % 12) / 2) mism++;
        check("cont_reqseq", mism, 0);
        check("cont_overlap", overlap_cnt, 0);
        check("cont_err", ec, exp_err);
        check("cont_xyz", {sx, sy, sz}, {d[0], d[1], d[2], d[3], d[4], d[5]});
        exp_x = {d[0], d[1]}; exp_y = {d[2], d[3]}; exp_z = {d[4], d[5]};

        // Random NACK plans
        for (int t = 0; t < 8; t++) begin
            if ($urandom_range(0, 1) == 1)
                plan[$urandom_range(0, 1)][$urandom_range(0, 5)] = $urandom_range(1, 4);
            run_attempt($sformatf("rand%0d", t), 1'b0, 1'b0);
        end
        check("final_overlap", overlap_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
